// File: rtl/simon_pipeline_sched_if.sv
// Request/response bundle for the Simon pipeline scheduler.
// master: requesters and result consumer; slave: the scheduler itself.
interface simon_pipeline_sched_if #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) ();
    logic [NREQ-1:0]    req_valid;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_data;
    logic [IDW-1:0]     out_id;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/simon_pipeline_sched.sv
// Round-robin scheduler in front of a fixed-latency Simon 32/64 pipeline.
// A valid/ID shift register mirrors the pipeline so each emerging ciphertext is
// tagged with its requester; credits reserve an output FIFO slot for every block
// in flight, so results are never dropped.
module simon_pipeline_sched #(
    parameter int unsigned LATENCY   = 32,
    parameter int unsigned NREQ      = 2,
    parameter int unsigned IDW       = 1,
    parameter int unsigned OUT_DEPTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    simon_pipeline_sched_if.slave        bus,
    output logic [31:0]                  pt_o,
    input  logic [31:0]                  ct_i,
    output logic [$clog2(LATENCY+1)-1:0] inflight,
    output logic                         idle
);
    localparam int unsigned IFW  = $clog2(LATENCY + 1);
    localparam int unsigned CNTW = $clog2(OUT_DEPTH + 1);
    localparam int unsigned AW   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    // Arbitration state
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            can_issue;
    logic            issue;
    logic [31:0]     pt_q, pt_d;

    // Pipeline tracking
    logic [LATENCY-1:0] valid_q;
    logic [IDW-1:0]     id_q [LATENCY];
    logic [IFW-1:0]     inflight_q, inflight_d;
    logic               push;
    logic [IDW-1:0]     exit_id;

    // Output FIFO
    logic [IDW+31:0] mem [OUT_DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CNTW-1:0] count_q, count_d;
    logic            pop;
    logic            not_empty;

    assign not_empty = (count_q != '0);
    assign pop       = not_empty & bus.out_ready;
    assign push      = valid_q[LATENCY-1];
    assign exit_id   = id_q[LATENCY-1];

    // Credit check and rotating-priority grant, starting the search at ptr_q.
    always_comb begin
        int unsigned pos;
        logic        found;
        grant     = '0;
        grant_id  = '0;
        pt_d      = pt_q;
        found     = 1'b0;
        pos       = 0;
        can_issue = (32'(inflight_q) + 32'(count_q)) < OUT_DEPTH;
        if (can_issue) begin
            for (int unsigned off = 0; off < NREQ; off++) begin
                pos = (32'(ptr_q) + off) % NREQ;
                for (int unsigned j = 0; j < NREQ; j++) begin
                    if (!found && (j == pos) && bus.req_valid[j]) begin
                        found    = 1'b1;
                        grant[j] = 1'b1;
                        grant_id = IDW'(j);
                        pt_d     = bus.req_data[32*j +: 32];
                    end
                end
            end
        end
    end

    assign issue         = |grant;
    assign bus.req_ready = grant;

    // Pointer advances past the winner only when a block is actually issued.
    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (32'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
        end
    end

    // In-flight and FIFO occupancy counters; simultaneous inc/dec cancel.
    always_comb begin
        inflight_d = inflight_q;
        if (issue && !push) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!issue && push) begin
            inflight_d = inflight_q - 1'b1;
        end
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state; reset discards everything in flight and empties the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q      <= '0;
            pt_q       <= '0;
            valid_q    <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            // pt_o holds on bubbles; the pipeline output for them is never captured
            if (issue) begin
                pt_q <= pt_d;
            end
            valid_q[0] <= issue;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
            if (push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    // ID tags travel alongside the valid bits; only meaningful where valid_q is set.
    always_ff @(posedge clk) begin
        id_q[0] <= grant_id;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            id_q[i] <= id_q[i-1];
        end
    end

    // FIFO storage: capture the ciphertext for a valid exiting block with its tag.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= {exit_id, ct_i};
        end
    end

    // Head is forced to zero while empty so the outputs read 0 after reset.
    always_comb begin
        bus.out_valid = not_empty;
        {bus.out_id, bus.out_data} = not_empty ? mem[rd_q] : '0;
    end

    assign pt_o     = pt_q;
    assign inflight = inflight_q;
    assign idle     = (inflight_q == '0) && !not_empty;

    // Credits make a push into a full FIFO unreachable.
    assert property (@(posedge clk) disable iff (!rst) push |-> (32'(count_q) < OUT_DEPTH));

endmodule

// File: tb/tb_simon_pipeline_sched.sv
// Directed bench for simon_pipeline_sched with an inverting fixed-latency pipeline stub.
module tb_simon_pipeline_sched;
    localparam int unsigned LATENCY   = 32;
    localparam int unsigned NREQ      = 2;
    localparam int unsigned IDW       = 1;
    localparam int unsigned OUT_DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pt_o;
    logic [31:0] ct_i;
    logic [5:0]  inflight;
    logic        idle;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0]    got_data [$];
    logic [IDW-1:0] got_id   [$];

    logic [31:0] stub [LATENCY-1];

    logic [1:0]  rr_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] rr_dat [4] = '{32'hCBA59483, 32'h87A96FBC, 32'hCBA59483, 32'h87A96FBC};

    simon_pipeline_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    simon_pipeline_sched #(
        .LATENCY  (LATENCY),
        .NREQ     (NREQ),
        .IDW      (IDW),
        .OUT_DEPTH(OUT_DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .pt_o    (pt_o),
        .ct_i    (ct_i),
        .inflight(inflight),
        .idle    (idle)
    );

    always #5 clk = ~clk;

    // Stub pipeline: ct_i is ~pt_o, sampled LATENCY edges after pt_o updates.
    always @(posedge clk) begin
        stub[0] <= ~pt_o;
        for (int i = 1; i < LATENCY - 1; i++) stub[i] <= stub[i-1];
    end
    assign ct_i = stub[LATENCY-2];

    // Record every popped result, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            got_data.push_back(bus.out_data);
            got_id.push_back(bus.out_id);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string tag, input int n, input int budget);
        int cyc;
        cyc = 0;
        while (got_data.size() < n && cyc < budget) begin
            tick();
            cyc++;
        end
        check(tag, 32'(got_data.size()), 32'(n));
    endtask

    initial begin
        int n;
        int sent;
        int stalls;
        int errs;
        logic [5:0] max_if;

        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b0;

        // Reset values
        #2 rst = 1'b0;
        #1;
        check("rst_pt", pt_o, 32'h0);
        check("rst_inflight", 32'(inflight), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_out_id", 32'(bus.out_id), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // Round-robin: both requesters valid for four cycles
        got_data.delete(); got_id.delete();
        bus.out_ready = 1'b1;
        bus.req_data  = {32'h78569043, 32'h345a6b7c};
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant", 32'(bus.req_ready), 32'(rr_rdy[k]));
            tick();
        end
        bus.req_valid = 2'b00;
        wait_out("rr_count", 4, 80);
        for (int k = 0; k < 4; k++) begin
            check("rr_data", got_data[k], rr_dat[k]);
            check("rr_id", 32'(got_id[k]), 32'(k % 2));
        end

        // Single block from requester 0
        got_data.delete(); got_id.delete();
        bus.req_data  = {32'h0, 32'h41424344};
        bus.req_valid = 2'b01;
        #1;
        check("single_ready", 32'(bus.req_ready), 32'b01);
        tick();
        bus.req_valid = 2'b00;
        check("single_pt", pt_o, 32'h41424344);
        check("single_inflight", 32'(inflight), 32'd1);
        check("single_busy", 32'(idle), 32'd0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check("single_latency", 32'(n), 32'(LATENCY));
        check("single_data", bus.out_data, 32'hBEBDBCBB);
        check("single_id", 32'(bus.out_id), 32'd0);
        check("single_inflight_0", 32'(inflight), 32'd0);
        tick();
        check("single_popped", 32'(bus.out_valid), 32'd0);
        check("single_idle", 32'(idle), 32'd1);

        // Back-to-back stream of 100 blocks
        got_data.delete(); got_id.delete();
        sent = 0; stalls = 0; max_if = '0; n = 0;
        while (sent < 100 && n < 300) begin
            bus.req_data  = {32'h0, 32'h10000000 + 32'(sent)};
            bus.req_valid = 2'b01;
            #1;
            if (bus.req_ready[0]) sent++;
            else stalls++;
            tick();
            if (inflight > max_if) max_if = inflight;
            n++;
        end
        bus.req_valid = 2'b00;
        check("tp_sent", 32'(sent), 32'd100);
        check("tp_stalls", 32'(stalls), 32'd0);
        check("tp_max_inflight", 32'(max_if), 32'(LATENCY));
        wait_out("tp_count", 100, 200);
        errs = 0;
        for (int k = 0; k < 100; k++) begin
            if (got_data[k] !== ~(32'h10000000 + 32'(k)) || got_id[k] !== 1'b0) errs++;
        end
        check("tp_order_errs", 32'(errs), 32'd0);

        // Backpressure: credits stop issue at OUT_DEPTH
        got_data.delete(); got_id.delete();
        bus.out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 120; c++) begin
            bus.req_data  = {32'h0, 32'h20000000 + 32'(sent)};
            bus.req_valid = 2'b01;
            #1;
            if (bus.req_ready[0]) sent++;
            tick();
        end
        check("bp_issued", 32'(sent), 32'(OUT_DEPTH));
        check("bp_ready_low", 32'(bus.req_ready), 32'd0);
        check("bp_inflight", 32'(inflight), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        #1;
        check("bp_no_early_credit", 32'(bus.req_ready), 32'd0);
        tick();
        check("bp_resume", 32'(bus.req_ready), 32'b01);
        bus.req_valid = 2'b00;
        wait_out("bp_count", 64, 100);
        errs = 0;
        for (int k = 0; k < 64; k++) begin
            if (got_data[k] !== ~(32'h20000000 + 32'(k))) errs++;
        end
        check("bp_order_errs", 32'(errs), 32'd0);

        // Simultaneous push and pop at count 3
        got_data.delete(); got_id.delete();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.req_data  = {32'h0, 32'h40000000 + 32'(k)};
            bus.req_valid = 2'b01;
            tick();
        end
        bus.req_valid = 2'b00;
        n = 0;
        while (!(bus.out_valid && inflight == 6'd1) && n < 80) begin
            tick();
            n++;
        end
        check("pp_inflight_1", 32'(inflight), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("pp_inflight_0", 32'(inflight), 32'd0);
        check("pp_head", bus.out_data, ~32'h40000001);
        bus.out_ready = 1'b1;
        wait_out("pp_count", 4, 20);
        for (int k = 0; k < 4; k++) begin
            check("pp_data", got_data[k], ~(32'h40000000 + 32'(k)));
        end
        repeat (3) tick();
        check("pp_empty", 32'(bus.out_valid), 32'd0);
        check("pp_no_extra", 32'(got_data.size()), 32'd4);

        // Mid-operation reset with ten blocks in flight
        got_data.delete(); got_id.delete();
        for (int k = 0; k < 10; k++) begin
            bus.req_data  = {32'h0, 32'h30000000 + 32'(k)};
            bus.req_valid = 2'b01;
            tick();
        end
        bus.req_valid = 2'b00;
        repeat (5) tick();
        check("mr_inflight_before", 32'(inflight), 32'd10);
        #2 rst = 1'b0;
        #1;
        check("mr_pt", pt_o, 32'h0);
        check("mr_inflight", 32'(inflight), 32'd0);
        check("mr_out_valid", 32'(bus.out_valid), 32'd0);
        check("mr_idle", 32'(idle), 32'd1);
        repeat (2) tick();
        rst = 1'b1;
        repeat (40) tick();
        check("mr_no_stale", 32'(got_data.size()), 32'd0);
        bus.req_data  = {32'h12345678, 32'h55AA00FF};
        bus.req_valid = 2'b11;
        #1;
        check("mr_ptr_reset", 32'(bus.req_ready), 32'b01);
        tick();
        bus.req_valid = 2'b00;
        check("mr_pt_new", pt_o, 32'h55AA00FF);
        wait_out("mr_count", 1, 50);
        check("mr_data", got_data[0], 32'hAA55FF00);
        check("mr_id", 32'(got_id[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
